// File: rtl/ysyx_22050710_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner encoding
// and default widths.
package ysyx_22050710_mem_arbiter_pkg;

    localparam int DEF_ADDR_WD      = 64;
    localparam int DEF_SRAM_DATA_WD = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IFU  = 2'd1,
        LSU  = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/ysyx_22050710_arb_pick.sv
// Combinational winner select between the IFU and LSU requests.
// YSYX_22050710_ARB_RR_EN selects round-robin on a tie (the last winner
// yields); otherwise the LSU always wins so the pipeline drains first.
module ysyx_22050710_arb_pick
    import ysyx_22050710_mem_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       ls_req,
    input  logic       last_lsu,
    output logic [1:0] pick
);

`ifdef YSYX_22050710_ARB_RR_EN
    // On a tie grant whichever requester did not win last time.
    always_comb begin
        pick = NONE;
        if (if_req && ls_req) begin
            pick = last_lsu ? IFU : LSU;
        end else if (ls_req) begin
            pick = LSU;
        end else if (if_req) begin
            pick = IFU;
        end
    end
`else
    // The last-winner history is meaningless under fixed priority.
    logic unused_last;
    assign unused_last = last_lsu;

    // Fixed priority: LSU over IFU.
    always_comb begin
        pick = NONE;
        if (ls_req) begin
            pick = LSU;
        end else if (if_req) begin
            pick = IFU;
        end
    end
`endif

endmodule

// File: rtl/ysyx_22050710_mem_arbiter.sv
// Two-requester arbiter for one SRAM-like port (IFU read-only, LSU read/write).
// One transaction outstanding: the winner is latched, issued in REQ until the
// memory accepts, then the response is routed back to its owner in WAIT.
// Optional macro YSYX_22050710_ARB_RR_EN enables round-robin arbitration.
module ysyx_22050710_mem_arbiter
    import ysyx_22050710_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WD      = DEF_ADDR_WD,
    parameter int SRAM_DATA_WD = DEF_SRAM_DATA_WD,
    parameter int WMASK_WD     = SRAM_DATA_WD / 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_if_req,
    input  logic [ADDR_WD-1:0]      i_if_addr,
    output logic                    o_if_addr_ok,
    output logic                    o_if_data_ok,
    output logic [SRAM_DATA_WD-1:0] o_if_rdata,
    input  logic                    i_ls_req,
    input  logic                    i_ls_wr,
    input  logic [ADDR_WD-1:0]      i_ls_addr,
    input  logic [WMASK_WD-1:0]     i_ls_wmask,
    input  logic [SRAM_DATA_WD-1:0] i_ls_wdata,
    output logic                    o_ls_addr_ok,
    output logic                    o_ls_data_ok,
    output logic [SRAM_DATA_WD-1:0] o_ls_rdata,
    output logic                    o_sram_req,
    output logic                    o_sram_wr,
    output logic [ADDR_WD-1:0]      o_sram_addr,
    output logic [WMASK_WD-1:0]     o_sram_wmask,
    output logic [SRAM_DATA_WD-1:0] o_sram_wdata,
    input  logic                    i_sram_addr_ok,
    input  logic                    i_sram_data_ok,
    input  logic [SRAM_DATA_WD-1:0] i_sram_rdata
);

    arb_state_t              state;
    arb_owner_t              owner;
    logic                    wr_q;
    logic [ADDR_WD-1:0]      addr_q;
    logic [WMASK_WD-1:0]     wmask_q;
    logic [SRAM_DATA_WD-1:0] wdata_q;

    logic                    last_lsu;
    logic [1:0]              pick_raw;
    arb_owner_t              pick;

    logic                    nxt_wr;
    logic [ADDR_WD-1:0]      nxt_addr;
    logic [WMASK_WD-1:0]     nxt_wmask;
    logic [SRAM_DATA_WD-1:0] nxt_wdata;

    logic                    in_req;
    logic                    addr_hs;
    logic                    data_hs;
    logic                    latch_en;

    ysyx_22050710_arb_pick u_pick (
        .if_req   (i_if_req),
        .ls_req   (i_ls_req),
        .last_lsu (last_lsu),
        .pick     (pick_raw)
    );

    assign pick = arb_owner_t'(pick_raw);

    // Handshakes only count in the state that expects them.
    assign in_req   = (state == REQ);
    assign addr_hs  = in_req && i_sram_addr_ok;
    assign data_hs  = (state == WAIT) && i_sram_data_ok;
    // A new transaction can be taken from IDLE or right as the current one ends.
    assign latch_en = (pick != NONE) && ((state == IDLE) || data_hs);

    // Payload of the winning requester; IFU fetches are plain reads.
    always_comb begin
        nxt_wr    = 1'b0;
        nxt_addr  = i_if_addr;
        nxt_wmask = '0;
        nxt_wdata = '0;
        if (pick == LSU) begin
            nxt_wr    = i_ls_wr;
            nxt_addr  = i_ls_addr;
            nxt_wmask = i_ls_wr ? i_ls_wmask : '0;
            nxt_wdata = i_ls_wr ? i_ls_wdata : '0;
        end
    end

    // Transaction FSM: state and owner of the outstanding request.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
            owner <= NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (latch_en) begin
                        state <= REQ;
                        owner <= pick;
                    end
                end
                REQ: begin
                    if (i_sram_addr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_sram_data_ok) begin
                        if (latch_en) begin
                            state <= REQ;
                            owner <= pick;
                        end else begin
                            state <= IDLE;
                            owner <= NONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= NONE;
                end
            endcase
        end
    end

    // Hold the accepted payload stable for as long as REQ lasts.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
        end else if (latch_en) begin
            wr_q    <= nxt_wr;
            addr_q  <= nxt_addr;
            wmask_q <= nxt_wmask;
            wdata_q <= nxt_wdata;
        end
    end

`ifdef YSYX_22050710_ARB_RR_EN
    // Remember who won last so a tie goes the other way next time.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_lsu <= 1'b0;
        end else if (latch_en) begin
            last_lsu <= (pick == LSU);
        end
    end
`else
    assign last_lsu = 1'b0;
`endif

    assign o_sram_req   = in_req;
    assign o_sram_wr    = in_req & wr_q;
    assign o_sram_addr  = in_req ? addr_q  : '0;
    assign o_sram_wmask = in_req ? wmask_q : '0;
    assign o_sram_wdata = in_req ? wdata_q : '0;

    assign o_if_addr_ok = addr_hs && (owner == IFU);
    assign o_ls_addr_ok = addr_hs && (owner == LSU);
    assign o_if_data_ok = data_hs && (owner == IFU);
    assign o_ls_data_ok = data_hs && (owner == LSU);

    // Store completions carry no data back.
    assign o_if_rdata = o_if_data_ok ? i_sram_rdata : '0;
    assign o_ls_rdata = (o_ls_data_ok && !wr_q) ? i_sram_rdata : '0;

endmodule

// File: tb/tb_ysyx_22050710_mem_arbiter.sv
// Directed plus randomized-traffic bench for ysyx_22050710_mem_arbiter.
module tb_ysyx_22050710_mem_arbiter;

    localparam logic [63:0] K = 64'hA5A5_5A5A_0F0F_F0F0;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [63:0] i_if_addr;
    logic        o_if_addr_ok;
    logic        o_if_data_ok;
    logic [63:0] o_if_rdata;
    logic        i_ls_req;
    logic        i_ls_wr;
    logic [63:0] i_ls_addr;
    logic [7:0]  i_ls_wmask;
    logic [63:0] i_ls_wdata;
    logic        o_ls_addr_ok;
    logic        o_ls_data_ok;
    logic [63:0] o_ls_rdata;
    logic        o_sram_req;
    logic        o_sram_wr;
    logic [63:0] o_sram_addr;
    logic [7:0]  o_sram_wmask;
    logic [63:0] o_sram_wdata;
    logic        i_sram_addr_ok;
    logic        i_sram_data_ok;
    logic [63:0] i_sram_rdata;

    int total = 0;
    int bad   = 0;

    logic any_out;
    assign any_out = |{o_if_addr_ok, o_if_data_ok, o_if_rdata, o_ls_addr_ok, o_ls_data_ok,
                       o_ls_rdata, o_sram_req, o_sram_wr, o_sram_addr, o_sram_wmask, o_sram_wdata};

    ysyx_22050710_mem_arbiter dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_if_req       (i_if_req),
        .i_if_addr      (i_if_addr),
        .o_if_addr_ok   (o_if_addr_ok),
        .o_if_data_ok   (o_if_data_ok),
        .o_if_rdata     (o_if_rdata),
        .i_ls_req       (i_ls_req),
        .i_ls_wr        (i_ls_wr),
        .i_ls_addr      (i_ls_addr),
        .i_ls_wmask     (i_ls_wmask),
        .i_ls_wdata     (i_ls_wdata),
        .o_ls_addr_ok   (o_ls_addr_ok),
        .o_ls_data_ok   (o_ls_data_ok),
        .o_ls_rdata     (o_ls_rdata),
        .o_sram_req     (o_sram_req),
        .o_sram_wr      (o_sram_wr),
        .o_sram_addr    (o_sram_addr),
        .o_sram_wmask   (o_sram_wmask),
        .o_sram_wdata   (o_sram_wdata),
        .i_sram_addr_ok (i_sram_addr_ok),
        .i_sram_data_ok (i_sram_data_ok),
        .i_sram_rdata   (i_sram_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge i_clk);
    endtask

    bit          exp_ls_first;
    bit          q_own[$];
    logic [63:0] q_dat[$];
    bit          own;
    logic [63:0] dat;
    int          if_left, ls_left, acnt, dcnt, ncyc;
    bit          mem_busy, if_drop, ls_drop;
    logic [63:0] mem_rd;

    initial begin
        i_rst = 1'b0;
        i_if_req = 0; i_if_addr = 0;
        i_ls_req = 0; i_ls_wr = 0; i_ls_addr = 0; i_ls_wmask = 0; i_ls_wdata = 0;
        i_sram_addr_ok = 0; i_sram_data_ok = 0; i_sram_rdata = 0;

        // Reset state
        cyc(); smp();
        chk("rst_outputs", any_out, 0);
        cyc(); i_rst = 1'b1;
        smp();
        chk("post_rst_idle", any_out, 0);

        // Test 1: LSU load alone
        cyc(); i_ls_req = 1; i_ls_wr = 0; i_ls_addr = 64'h8000_0010;
        smp();
        chk("t1_n_no_req", o_sram_req, 0);
        cyc(); i_sram_addr_ok = 1;
        smp();
        chk("t1_n1_req", o_sram_req, 1);
        chk("t1_n1_addr", o_sram_addr, 64'h8000_0010);
        chk("t1_n1_wr", o_sram_wr, 0);
        chk("t1_n1_wmask", o_sram_wmask, 0);
        chk("t1_n1_ls_ack", o_ls_addr_ok, 1);
        chk("t1_n1_if_ack", o_if_addr_ok, 0);
        cyc(); i_ls_req = 0; i_sram_addr_ok = 0; i_sram_data_ok = 1; i_sram_rdata = 64'hDEAD_BEEF;
        smp();
        chk("t1_n2_ls_dok", o_ls_data_ok, 1);
        chk("t1_n2_ls_rdata", o_ls_rdata, 64'hDEAD_BEEF);
        chk("t1_n2_if_dok", o_if_data_ok, 0);
        chk("t1_n2_if_rdata", o_if_rdata, 0);
        cyc(); i_sram_data_ok = 0; i_sram_rdata = 0;
        smp();
        chk("t1_n3_idle_req", o_sram_req, 0);
        chk("t1_n3_ls_dok", o_ls_data_ok, 0);

        // Test 2: simultaneous requests
`ifdef YSYX_22050710_ARB_RR_EN
        exp_ls_first = 1'b0;
`else
        exp_ls_first = 1'b1;
`endif
        cyc(); i_if_req = 1; i_if_addr = 64'h1000; i_ls_req = 1; i_ls_wr = 0; i_ls_addr = 64'h2000;
        smp();
        cyc(); i_sram_addr_ok = 1;
        smp();
        chk("t2_first_addr", o_sram_addr, exp_ls_first ? 64'h2000 : 64'h1000);
        chk("t2_first_ls_ack", o_ls_addr_ok, exp_ls_first);
        chk("t2_first_if_ack", o_if_addr_ok, !exp_ls_first);
        cyc(); i_sram_addr_ok = 0; i_sram_data_ok = 1; i_sram_rdata = 64'h55;
        if (exp_ls_first) i_ls_req = 0; else i_if_req = 0;
        smp();
        chk("t2_first_ls_dok", o_ls_data_ok, exp_ls_first);
        chk("t2_first_if_dok", o_if_data_ok, !exp_ls_first);
        chk("t2_first_rdata", exp_ls_first ? o_ls_rdata : o_if_rdata, 64'h55);
        cyc(); i_sram_data_ok = 0; i_sram_rdata = 0;
        smp();
        chk("t2_b2b_req", o_sram_req, 1);
        chk("t2_second_addr", o_sram_addr, exp_ls_first ? 64'h1000 : 64'h2000);
        chk("t2_second_no_ack", o_if_addr_ok | o_ls_addr_ok, 0);
        cyc(); i_sram_addr_ok = 1;
        smp();
        chk("t2_second_if_ack", o_if_addr_ok, exp_ls_first);
        chk("t2_second_ls_ack", o_ls_addr_ok, !exp_ls_first);
        cyc(); i_if_req = 0; i_ls_req = 0; i_sram_addr_ok = 0; i_sram_data_ok = 1; i_sram_rdata = 64'h66;
        smp();
        chk("t2_second_if_dok", o_if_data_ok, exp_ls_first);
        chk("t2_second_rdata", exp_ls_first ? o_if_rdata : o_ls_rdata, 64'h66);
        chk("t2_other_rdata", exp_ls_first ? o_ls_rdata : o_if_rdata, 0);
        cyc(); i_sram_data_ok = 0; i_sram_rdata = 0;
        smp();
        chk("t2_idle", o_sram_req, 0);

        // Test 3: store with addr_ok held low three cycles
        cyc(); i_ls_req = 1; i_ls_wr = 1; i_ls_addr = 64'h8000_0100; i_ls_wmask = 8'h0F; i_ls_wdata = 64'h1122_3344;
        smp();
        for (int i = 0; i < 3; i++) begin
            cyc(); smp();
            chk("t3_hold_req", o_sram_req, 1);
            chk("t3_hold_wr", o_sram_wr, 1);
            chk("t3_hold_addr", o_sram_addr, 64'h8000_0100);
            chk("t3_hold_wmask", o_sram_wmask, 8'h0F);
            chk("t3_hold_wdata", o_sram_wdata, 64'h1122_3344);
            chk("t3_hold_no_ack", o_ls_addr_ok, 0);
        end
        cyc(); i_sram_addr_ok = 1;
        smp();
        chk("t3_ack", o_ls_addr_ok, 1);
        cyc(); i_ls_req = 0; i_ls_wr = 0; i_ls_wmask = 0; i_ls_wdata = 0;
        i_sram_addr_ok = 0; i_sram_data_ok = 1; i_sram_rdata = 64'hFFFF;
        smp();
        chk("t3_ack_single", o_ls_addr_ok, 0);
        chk("t3_store_dok", o_ls_data_ok, 1);
        chk("t3_store_rdata", o_ls_rdata, 0);
        cyc(); i_sram_data_ok = 0; i_sram_rdata = 0;
        smp();

        // Test 4: spurious data_ok in IDLE and REQ
        cyc(); i_sram_data_ok = 1; i_sram_rdata = 64'h77;
        smp();
        chk("t4_idle_dok", o_if_data_ok | o_ls_data_ok, 0);
        cyc(); i_if_req = 1; i_if_addr = 64'h4000;
        smp();
        chk("t4_idle2_dok", o_if_data_ok | o_ls_data_ok, 0);
        cyc(); smp();
        chk("t4_req_dok", o_if_data_ok | o_ls_data_ok, 0);
        chk("t4_req_req", o_sram_req, 1);
        cyc(); i_sram_addr_ok = 1;
        smp();
        chk("t4_req_ack", o_if_addr_ok, 1);
        chk("t4_req_ack_dok", o_if_data_ok, 0);
        cyc(); i_if_req = 0; i_sram_addr_ok = 0;
        smp();
        chk("t4_wait_dok", o_if_data_ok, 1);
        chk("t4_wait_rdata", o_if_rdata, 64'h77);
        cyc(); i_sram_data_ok = 0; i_sram_rdata = 0;
        smp();

        // Test 5: reset while in WAIT
        cyc(); i_if_req = 1; i_if_addr = 64'h3000;
        smp();
        cyc(); i_sram_addr_ok = 1;
        smp();
        chk("t5_ack", o_if_addr_ok, 1);
        cyc(); i_if_req = 0; i_sram_addr_ok = 0;
        i_rst = 1'b0;
        #1;
        chk("t5_rst_outputs", any_out, 0);
        i_sram_data_ok = 1; i_sram_rdata = 64'h88;
        smp();
        chk("t5_rst_dok", o_if_data_ok | o_ls_data_ok, 0);
        i_rst = 1'b1;
        cyc(); smp();
        chk("t5_stale_dok", o_if_data_ok | o_ls_data_ok, 0);
        chk("t5_stale_rdata", o_if_rdata, 0);
        cyc(); i_sram_data_ok = 0; i_sram_rdata = 0; i_if_req = 1; i_if_addr = 64'h5000;
        smp();
        cyc(); i_sram_addr_ok = 1;
        smp();
        chk("t5_fresh_addr", o_sram_addr, 64'h5000);
        chk("t5_fresh_ack", o_if_addr_ok, 1);
        cyc(); i_if_req = 0; i_sram_addr_ok = 0; i_sram_data_ok = 1; i_sram_rdata = 64'h99;
        smp();
        chk("t5_fresh_dok", o_if_data_ok, 1);
        chk("t5_fresh_rdata", o_if_rdata, 64'h99);
        cyc(); i_sram_data_ok = 0; i_sram_rdata = 0;
        smp();

        // Test 6: 100 random interleaved requests with random memory delays
        if_left = 50; ls_left = 50; ncyc = 0;
        mem_busy = 0; if_drop = 0; ls_drop = 0;
        acnt = $urandom_range(0, 4); dcnt = 0; mem_rd = 0;
        while (ncyc < 4000 && !(if_left == 0 && ls_left == 0 && !i_if_req && !i_ls_req && q_own.size() == 0)) begin
            ncyc++;
            cyc();
            if (if_drop) begin i_if_req = 0; if_drop = 0; end
            if (ls_drop) begin i_ls_req = 0; ls_drop = 0; end
            if (!i_if_req && if_left > 0 && $urandom_range(0, 2) == 0) begin
                i_if_req = 1; i_if_addr = {$urandom, $urandom}; i_if_addr[2:0] = 3'b0; if_left--;
            end
            if (!i_ls_req && ls_left > 0 && $urandom_range(0, 2) == 0) begin
                i_ls_req = 1; i_ls_wr = 1'($urandom_range(0, 1)); i_ls_addr = {$urandom, $urandom};
                i_ls_wmask = 8'($urandom); i_ls_wdata = {$urandom, $urandom}; ls_left--;
            end
            i_sram_addr_ok = 0; i_sram_data_ok = 0; i_sram_rdata = 0;
            if (mem_busy) begin
                if (dcnt == 0) begin
                    i_sram_data_ok = 1; i_sram_rdata = mem_rd; mem_busy = 0; acnt = $urandom_range(0, 4);
                end else begin
                    dcnt--;
                end
            end else if (o_sram_req) begin
                if (acnt == 0) begin
                    i_sram_addr_ok = 1; mem_rd = o_sram_addr ^ K; mem_busy = 1; dcnt = $urandom_range(0, 4);
                end else begin
                    acnt--;
                end
            end
            smp();
            chk("rnd_ack_onehot", o_if_addr_ok & o_ls_addr_ok, 0);
            chk("rnd_dok_onehot", o_if_data_ok & o_ls_data_ok, 0);
            if (o_if_data_ok || o_ls_data_ok) begin
                chk("rnd_sb_empty", 64'(q_own.size() == 0), 0);
                if (q_own.size() != 0) begin
                    own = q_own.pop_front();
                    dat = q_dat.pop_front();
                    chk("rnd_owner", o_ls_data_ok, own);
                    chk("rnd_rdata", own ? o_ls_rdata : o_if_rdata, dat);
                end
            end
            if (o_ls_addr_ok) begin
                chk("rnd_ls_held", i_ls_req, 1);
                chk("rnd_ls_addr", o_sram_addr, i_ls_addr);
                chk("rnd_ls_wr", o_sram_wr, i_ls_wr);
                chk("rnd_ls_wmask", o_sram_wmask, i_ls_wr ? i_ls_wmask : 8'h0);
                chk("rnd_ls_wdata", o_sram_wdata, i_ls_wr ? i_ls_wdata : 64'h0);
                q_own.push_back(1'b1);
                q_dat.push_back(i_ls_wr ? 64'h0 : (i_ls_addr ^ K));
                ls_drop = 1;
            end
            if (o_if_addr_ok) begin
                chk("rnd_if_held", i_if_req, 1);
                chk("rnd_if_addr", o_sram_addr, i_if_addr);
                chk("rnd_if_wr", o_sram_wr, 0);
                q_own.push_back(1'b0);
                q_dat.push_back(i_if_addr ^ K);
                if_drop = 1;
            end
        end
        chk("rnd_all_issued", 64'(if_left + ls_left), 0);
        chk("rnd_drained", 64'(q_own.size()), 0);
        chk("rnd_reqs_released", {i_if_req, i_ls_req}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
